// File: rtl/ariane_pkg.sv
// Slice of ariane_pkg: the accelerator port payload types shared by the
// harts and the accelerator, plus the arbiter depth used at top level.
package ariane_pkg;

    // Outstanding accelerator requests the shared-port arbiter can track.
    localparam int unsigned AccArbMaxOutstanding = 4;

    typedef struct packed {
        logic [31:0] insn;
        logic [63:0] rs1;
        logic [63:0] rs2;
    } accelerator_req_t;

    typedef struct packed {
        logic [4:0]  id;
        logic [63:0] result;
        logic        error;
    } accelerator_resp_t;

endpackage

// File: rtl/acc_id_fifo.sv
// In-order FIFO of requester indices. Records which hart owns each request
// in flight so responses, which return in order, can be routed back.
module acc_id_fifo #(
    parameter int Depth = 4,
    parameter int Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] head_o
);

    localparam int PtrW = $clog2(Depth);
    // One extra bit so a full FIFO is distinguishable from an empty one.
    localparam int CntW = PtrW + 1;

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [Width-1:0] mem_q [Depth];
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is ignored; a pop from an empty one is ignored.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Next pointer/count; pointers wrap naturally since Depth is a power of 2.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state: pointers and occupancy, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage: only meaningful behind the pointers, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/acc_req_arbiter.sv
// Shares one accelerator request/response port among NrHarts requesters.
// Round-robin request arbitration with a grant lock while the accelerator
// stalls; an in-order ID FIFO steers each response back to its issuer.
module acc_req_arbiter
    import ariane_pkg::*;
#(
    parameter int NrHarts        = 2,
    parameter int MaxOutstanding = int'(AccArbMaxOutstanding),
    parameter int IdxW           = $clog2(NrHarts)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  accelerator_req_t [NrHarts-1:0]   hart_req_i,
    input  logic [NrHarts-1:0]               hart_req_valid_i,
    output logic [NrHarts-1:0]               hart_req_ready_o,
    output accelerator_resp_t                hart_resp_o,
    output logic [NrHarts-1:0]               hart_resp_valid_o,
    input  logic [NrHarts-1:0]               hart_resp_ready_i,
    output accelerator_req_t                 acc_req_o,
    output logic                             acc_req_valid_o,
    input  logic                             acc_req_ready_i,
    input  accelerator_resp_t                acc_resp_i,
    input  logic                             acc_resp_valid_i,
    output logic                             acc_resp_ready_o,
    output logic                             busy_o,
    output logic                             err_o
);

    logic [IdxW-1:0] prio_q, prio_d;
    logic            lock_q, lock_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic            err_q, err_d;

    logic [IdxW-1:0] grant;
    logic            found;
    int              idx;
    logic            req_hs;
    logic            resp_hs;
    logic            fifo_full;
    logic            fifo_empty;
    logic [IdxW-1:0] fifo_head;

    // Grant selection: locked index while stalled, else first valid at/after prio_q.
    always_comb begin
        grant = prio_q;
        found = 1'b0;
        idx   = 0;
        if (lock_q) begin
            grant = lock_idx_q;
        end else begin
            for (int k = 0; k < NrHarts; k++) begin
                idx = (int'(prio_q) + k) % NrHarts;
                if (!found && hart_req_valid_i[idx]) begin
                    grant = IdxW'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    // Request path; outputs are held quiet while reset is asserted.
    always_comb begin
        acc_req_o        = hart_req_i[grant];
        acc_req_valid_o  = (|hart_req_valid_i) & ~fifo_full & ~rst_i;
        hart_req_ready_o = '0;
        for (int i = 0; i < NrHarts; i++) begin
            hart_req_ready_o[i] = acc_req_ready_i & (grant == IdxW'(i)) & ~fifo_full & ~rst_i;
        end
    end

    assign req_hs = acc_req_valid_o & acc_req_ready_i;

    // Response routing: head of the ID FIFO owns the response; with nothing
    // outstanding the response is accepted and dropped.
    always_comb begin
        hart_resp_o       = acc_resp_i;
        hart_resp_valid_o = '0;
        acc_resp_ready_o  = 1'b1;
        if (!fifo_empty) begin
            hart_resp_valid_o[fifo_head] = acc_resp_valid_i;
            acc_resp_ready_o             = hart_resp_ready_i[fifo_head];
        end
    end

    assign resp_hs = acc_resp_valid_i & acc_resp_ready_o & ~fifo_empty;

    // Next-state for priority pointer, grant lock and sticky error flag.
    always_comb begin
        prio_d     = prio_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        err_d      = err_q | (fifo_empty & acc_resp_valid_i);
        if (req_hs) begin
            prio_d = IdxW'((int'(grant) + 1) % NrHarts);
            lock_d = 1'b0;
        end else if (acc_req_valid_o) begin
            lock_d     = 1'b1;
            lock_idx_d = grant;
        end
    end

    // Arbiter control state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio_q     <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            prio_q     <= prio_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            err_q      <= err_d;
        end
    end

    acc_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdxW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (req_hs),
        .data_i  (grant),
        .pop_i   (resp_hs),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    assign busy_o = ~fifo_empty;
    assign err_o  = err_q;

endmodule

// File: tb/tb_acc_req_arbiter.sv
// Directed bench for acc_req_arbiter with two harts and a 4-deep ID FIFO.
module tb_acc_req_arbiter;
    import ariane_pkg::*;

    logic                   clk;
    logic                   rst;
    accelerator_req_t [1:0] hreq;
    logic [1:0]             hvalid;
    logic [1:0]             hready;
    accelerator_resp_t      hresp;
    logic [1:0]             hresp_valid;
    logic [1:0]             hresp_ready;
    accelerator_req_t       areq;
    logic                   areq_valid;
    logic                   areq_ready;
    accelerator_resp_t      aresp;
    logic                   aresp_valid;
    logic                   aresp_ready;
    logic                   busy;
    logic                   err;

    int n_total = 0;
    int n_pass  = 0;

    localparam logic [63:0] InsnA = 64'hAAAA0000;
    localparam logic [63:0] InsnB = 64'hBBBB1111;

    acc_req_arbiter #(
        .NrHarts        (2),
        .MaxOutstanding (4)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .hart_req_i        (hreq),
        .hart_req_valid_i  (hvalid),
        .hart_req_ready_o  (hready),
        .hart_resp_o       (hresp),
        .hart_resp_valid_o (hresp_valid),
        .hart_resp_ready_i (hresp_ready),
        .acc_req_o         (areq),
        .acc_req_valid_o   (areq_valid),
        .acc_req_ready_i   (areq_ready),
        .acc_resp_i        (aresp),
        .acc_resp_valid_i  (aresp_valid),
        .acc_resp_ready_o  (aresp_ready),
        .busy_o            (busy),
        .err_o             (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        hreq        = '0;
        hreq[0].insn = InsnA[31:0];
        hreq[1].insn = InsnB[31:0];
        hvalid      = 2'b11;
        hresp_ready = 2'b11;
        areq_ready  = 1'b1;
        aresp       = '0;
        aresp.result = 64'h1234_5678_9ABC_DEF0;
        aresp_valid = 1'b0;

        // Reset state (requesters valid, outputs must stay quiet)
        #2;
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_areq_valid", areq_valid, 0);
        check("rst_hready", hready, 2'b00);
        check("rst_hresp_valid", hresp_valid, 2'b00);
        check("rst_aresp_ready", aresp_ready, 1);
        tick();
        hvalid = 2'b00;
        rst    = 1'b0;

        // Contention: alternating grants, responses one cycle later
        tick(); hvalid = 2'b11; #1;
        check("c1_areq_valid", areq_valid, 1);
        check("c1_hready", hready, 2'b01);
        check("c1_insn", areq.insn, InsnA);
        tick(); aresp_valid = 1'b1; #1;
        check("c2_hresp_valid", hresp_valid, 2'b01);
        check("c2_hready", hready, 2'b10);
        check("c2_insn", areq.insn, InsnB);
        check("c2_hresp_result", hresp.result, 64'h1234_5678_9ABC_DEF0);
        tick(); #1;
        check("c3_hresp_valid", hresp_valid, 2'b10);
        check("c3_hready", hready, 2'b01);
        tick(); #1;
        check("c4_hresp_valid", hresp_valid, 2'b01);
        check("c4_hready", hready, 2'b10);
        tick(); hvalid = 2'b00; #1;
        check("c5_hresp_valid", hresp_valid, 2'b10);
        check("c5_areq_valid", areq_valid, 0);
        tick(); aresp_valid = 1'b0; #1;
        check("c6_busy", busy, 0);
        check("c6_prio", dut.prio_q, 0);

        // Lock: hart 1 stalled three cycles while hart 0 joins
        tick(); hvalid = 2'b10; areq_ready = 1'b0; #1;
        check("l1_areq_valid", areq_valid, 1);
        check("l1_hready", hready, 2'b00);
        check("l1_insn", areq.insn, InsnB);
        tick(); hvalid = 2'b11; #1;
        check("l2_insn", areq.insn, InsnB);
        check("l2_hready", hready, 2'b00);
        tick(); #1;
        check("l3_insn", areq.insn, InsnB);
        tick(); areq_ready = 1'b1; #1;
        check("l4_hready", hready, 2'b10);
        check("l4_insn", areq.insn, InsnB);
        tick(); #1;
        check("l5_hready", hready, 2'b01);
        check("l5_insn", areq.insn, InsnA);
        check("l5_prio", dut.prio_q, 0);
        tick(); hvalid = 2'b00; aresp_valid = 1'b1; #1;
        check("l6_busy", busy, 1);
        check("l6_hresp_valid", hresp_valid, 2'b10);
        tick(); #1;
        check("l7_hresp_valid", hresp_valid, 2'b01);
        tick(); aresp_valid = 1'b0; #1;
        check("l8_busy", busy, 0);

        // Full: four accepts, fifth blocked until one response pops
        tick(); hvalid = 2'b01; #1;
        check("f_acc0", hready, 2'b01);
        for (int i = 1; i < 4; i++) begin
            tick(); #1;
            check("f_acc", hready, 2'b01);
        end
        tick(); #1;
        check("f_full_areq_valid", areq_valid, 0);
        check("f_full_busy", busy, 1);
        check("f_full_hready", hready, 2'b00);
        aresp_valid = 1'b1; #1;
        check("f_pop_hresp_valid", hresp_valid, 2'b01);
        check("f_pop_aresp_ready", aresp_ready, 1);
        check("f_pop_areq_valid", areq_valid, 0);
        tick(); aresp_valid = 1'b0; #1;
        check("f_5th_areq_valid", areq_valid, 1);
        check("f_5th_hready", hready, 2'b01);
        tick(); hvalid = 2'b00; aresp_valid = 1'b1; #1;
        check("f_refull_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            check("f_drain_hresp_valid", hresp_valid, 2'b01);
            tick(); #1;
        end
        aresp_valid = 1'b0; #1;
        check("f_drained_busy", busy, 0);

        // Backpressure from head hart 1
        tick(); hvalid = 2'b10; #1;
        check("b_hready", hready, 2'b10);
        tick(); hvalid = 2'b00; aresp_valid = 1'b1; hresp_ready = 2'b01; #1;
        check("b_stall_aresp_ready", aresp_ready, 0);
        check("b_stall_hresp_valid", hresp_valid, 2'b10);
        tick(); #1;
        check("b_nopop_busy", busy, 1);
        hresp_ready = 2'b11; #1;
        check("b_go_aresp_ready", aresp_ready, 1);
        check("b_go_hresp_valid", hresp_valid, 2'b10);
        tick(); aresp_valid = 1'b0; #1;
        check("b_done_busy", busy, 0);

        // Spurious response with nothing outstanding
        aresp_valid = 1'b1; #1;
        check("s_aresp_ready", aresp_ready, 1);
        check("s_hresp_valid", hresp_valid, 2'b00);
        check("s_err_before", err, 0);
        tick(); aresp_valid = 1'b0; #1;
        check("s_err_set", err, 1);
        tick(); #1;
        check("s_err_sticky", err, 1);

        // Reset mid-flight with two outstanding
        hvalid = 2'b01;
        tick();
        tick(); hvalid = 2'b00; #1;
        check("r_pre_busy", busy, 1);
        check("r_pre_prio", dut.prio_q, 1);
        rst = 1'b1; #1;
        check("r_busy", busy, 0);
        check("r_prio", dut.prio_q, 0);
        check("r_err", err, 0);
        check("r_aresp_ready", aresp_ready, 1);
        #2; rst = 1'b0;
        hvalid = 2'b11; aresp_valid = 1'b1; #1;
        check("r_first_grant", hready, 2'b01);
        check("r_first_insn", areq.insn, InsnA);
        tick(); hvalid = 2'b00; aresp_valid = 1'b0; #1;
        check("r_late_resp_err", err, 1);
        check("r_after_busy", busy, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
